shared_reg_arbiter: RTL and testbench



---
 rtl/shared_reg_arbiter.sv | 173 +++++++++++++++++
 tb/tb_shared_reg_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_reg_arbiter.sv
// -----------------------------------------------------------------------------
// shared_reg_arbiter
//
// Round-robin arbiter that shares one WIDTH-bit storage register between NREQ
// requester units. One requester at a time owns write access. An owner that
// has held the grant for MAX_HOLD cycles is preempted as soon as any other
// requester is waiting. Every hand-over passes through exactly one IDLE cycle.
//
// Optional feature (compile-time macro ARB_ERR_EN):
//   defined     -> ERR is a sticky flag that sets on any write-enable from a
//                  requester that does not hold the grant (including IDLE).
//   not defined -> ERR is tied low and no error logic exists.
//
// Ports:
//   CLK    in   1           clock, rising edge
//   RST    in   1           asynchronous, active-high reset
//   REQ    in   NREQ        per-requester access request (level)
//   WE     in   NREQ        per-requester write enable
//   WDATA  in   NREQ*WIDTH  write data, requester i owns [i*WIDTH +: WIDTH]
//   GNT    out  NREQ        one-hot grant, registered (zero while IDLE)
//   OWNER  out  IW          index of current owner, holds last value when idle
//   BUSY   out  1           high while the FSM is in OWN (state visibility)
//   Q      out  WIDTH       shared register contents (common read bus)
//   ERR    out  1           sticky protocol-error flag (see ARB_ERR_EN)
//
// Handshake: REQ[i] is a level request. The requester raises REQ[i] and keeps
// it high for as long as it wants the register; GNT[i] high means it owns the
// register in that cycle and its WE/WDATA are honoured at the next edge while
// REQ[i] is still high. Dropping REQ[i] releases ownership at the next edge,
// and a write presented in that same cycle is discarded. If GNT[i] falls
// while REQ[i] is still high the requester was preempted and stays queued.
// -----------------------------------------------------------------------------
module shared_reg_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          REQ,
  input  logic [NREQ-1:0]          WE,
  input  logic [NREQ*WIDTH-1:0]    WDATA,
  output logic [NREQ-1:0]          GNT,
  output logic [$clog2(NREQ)-1:0]  OWNER,
  output logic                     BUSY,
  output logic [WIDTH-1:0]         Q,
  output logic                     ERR
);

  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [HW-1:0]   hcnt;

  // Round-robin search results (used in IDLE)
  logic            found;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   cand;
  logic [NREQ-1:0] win_onehot;

  // Owner-side decode (used in OWN)
  logic             owner_req;
  logic             owner_we;
  logic [WIDTH-1:0] owner_data;
  logic             others_pending;
  logic             preempt;
  logic             release_now;
  logic [IW-1:0]    next_ptr;

  // First set REQ bit scanning ptr, ptr+1, ... with wrap modulo NREQ.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!found && REQ[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    win_onehot         = '0;
    win_onehot[winner] = 1'b1;
  end

  // In OWN, GNT is exactly onehot(OWNER), so masking REQ with ~GNT leaves
  // only the requesters that are waiting behind the owner.
  always_comb begin
    owner_req      = REQ[OWNER];
    owner_we       = WE[OWNER];
    owner_data     = WDATA[OWNER*WIDTH +: WIDTH];
    others_pending = |(REQ & ~GNT);
    preempt        = (hcnt == HOLD_MAX) && others_pending;
    release_now    = !owner_req;
    next_ptr       = (OWNER == LAST_IDX) ? '0 : OWNER + 1'b1;
  end

  // Arbitration FSM. BUSY mirrors the state so the FSM is observable
  // directly on the port list.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      ptr   <= '0;
      hcnt  <= '0;
      GNT   <= '0;
      OWNER <= '0;
      BUSY  <= 1'b0;
      Q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            GNT   <= win_onehot;
            OWNER <= winner;
            BUSY  <= 1'b1;
            hcnt  <= HW'(1);
            state <= OWN;
          end
        end

        OWN: begin
          // The owner's write still lands in the cycle it gets preempted;
          // a write together with a dropped REQ is discarded.
          if (owner_req && owner_we) begin
            Q <= owner_data;
          end

          if (release_now || preempt) begin
            GNT   <= '0;
            BUSY  <= 1'b0;
            ptr   <= next_ptr;
            hcnt  <= '0;
            state <= IDLE;
          end else if (hcnt != HOLD_MAX) begin
            hcnt <= hcnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ARB_ERR_EN
  // Sticky: any write-enable from a requester without the grant, which also
  // covers every write attempt while IDLE (GNT is zero then).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ERR <= 1'b0;
    end else if (|(WE & ~GNT)) begin
      ERR <= 1'b1;
    end
  end
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_reg_arbiter
//
// Directed bench for shared_reg_arbiter (NREQ=4, WIDTH=8, MAX_HOLD=4).
// The driver applies one cycle of inputs at a time and pushes the expected
// post-edge outputs, tagged with the cycle number they belong to, onto
// exp_q. An independent monitor samples on the falling edge and compares
// each entry whose cycle has arrived. Asynchronous-reset behaviour is
// checked directly by the driver in the middle of a cycle.
// -----------------------------------------------------------------------------
module tb_shared_reg_arbiter;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;
  localparam int W        = 40;

`ifdef ARB_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic                  CLK;
  logic                  RST;
  logic [NREQ-1:0]       REQ;
  logic [NREQ-1:0]       WE;
  logic [NREQ*WIDTH-1:0] WDATA;
  logic [NREQ-1:0]       GNT;
  logic [1:0]            OWNER;
  logic                  BUSY;
  logic [WIDTH-1:0]      Q;
  logic                  ERR;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cycle_cnt = 0;
  always @(posedge CLK) cycle_cnt <= cycle_cnt + 1;

  shared_reg_arbiter #(
    .NREQ     (NREQ),
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .REQ   (REQ),
    .WE    (WE),
    .WDATA (WDATA),
    .GNT   (GNT),
    .OWNER (OWNER),
    .BUSY  (BUSY),
    .Q     (Q),
    .ERR   (ERR)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // entry: [39:24] cycle, [23:20] gnt, [19] busy, [18:17] owner,
  //        [16:9] q, [8] check err, [7] err, [6:0] unused
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  logic [W-1:0] mon_e;
  always @(negedge CLK) begin
    while (exp_q.size() > 0 && int'(exp_q[0][39:24]) <= cycle_cnt) begin
      mon_e = exp_q.pop_front();
      if (int'(mon_e[39:24]) < cycle_cnt) begin
        chk("stale_entry", 32'(cycle_cnt), 32'(mon_e[39:24]));
      end else begin
        chk("gnt",   32'(GNT),   32'(mon_e[23:20]));
        chk("busy",  32'(BUSY),  32'(mon_e[19]));
        chk("owner", 32'(OWNER), 32'(mon_e[18:17]));
        chk("q",     32'(Q),     32'(mon_e[16:9]));
        if (mon_e[8]) chk("err", 32'(ERR), 32'(mon_e[7]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at posedge+1; return at the next posedge+1)
  // ---------------------------------------------------------------------------
  task automatic cyc(input logic [3:0] req, input logic [3:0] we, input logic [31:0] wd,
                     input logic [3:0] eg, input logic eb, input logic [1:0] eo,
                     input logic [7:0] eq, input logic ce, input logic ee);
    REQ   = req;
    WE    = we;
    WDATA = wd;
    exp_q.push_back({16'(cycle_cnt + 1), eg, eb, eo, eq, ce, ee, 7'd0});
    @(posedge CLK);
    #1;
  endtask

  task automatic cy(input logic [3:0] req, input logic [3:0] we, input logic [31:0] wd,
                    input logic [3:0] eg, input logic eb, input logic [1:0] eo,
                    input logic [7:0] eq);
    cyc(req, we, wd, eg, eb, eo, eq, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_q"},     32'(Q),     32'h0);
    chk({tag, "_gnt"},   32'(GNT),   32'h0);
    chk({tag, "_busy"},  32'(BUSY),  32'h0);
    chk({tag, "_owner"}, 32'(OWNER), 32'h0);
    chk({tag, "_err"},   32'(ERR),   32'h0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST   = 1'b1;
    REQ   = '0;
    WE    = '0;
    WDATA = '0;
    @(posedge CLK);
    @(posedge CLK);
    #3;
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [7:0]  prev_q;
  logic [7:0]  d;
  logic [3:0]  oh;
  logic [31:0] wd_rr;

  initial begin
    RST   = 1'b1;
    REQ   = '0;
    WE    = '0;
    WDATA = '0;
    #12;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    chk_reset_vals("por");

    // --- Mid-cycle asynchronous reset with Q=A5, GNT=0010 ---------------
    cy(4'b0010, 4'b0000, 32'h0000_0000, 4'b0010, 1'b1, 2'd1, 8'h00);
    cy(4'b0010, 4'b0010, 32'h0000_A500, 4'b0010, 1'b1, 2'd1, 8'hA5);
    @(negedge CLK);
    #1;
    RST = 1'b1;
    REQ = '0;
    WE  = '0;
    #1;
    chk("async_rst_q",     32'(Q),     32'h0);
    chk("async_rst_gnt",   32'(GNT),   32'h0);
    chk("async_rst_busy",  32'(BUSY),  32'h0);
    chk("async_rst_owner", 32'(OWNER), 32'h0);
    @(posedge CLK);
    @(posedge CLK);
    #3;
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // --- Single owner, no preemption while alone --------------------------
    cy(4'b0100, 4'b0100, 32'h003C_0000, 4'b0100, 1'b1, 2'd2, 8'h00);
    cy(4'b0100, 4'b0100, 32'h003C_0000, 4'b0100, 1'b1, 2'd2, 8'h3C);
    for (int i = 0; i < 10; i++) begin
      cy(4'b0100, 4'b0000, 32'h0000_0000, 4'b0100, 1'b1, 2'd2, 8'h3C);
    end
    cy(4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 2'd2, 8'h3C);
    do_reset();

    // --- Round robin: all requesting, 0,1,2,3,0 ---------------------------
    wd_rr  = 32'h4433_2211;
    prev_q = 8'h00;
    for (int k = 0; k < 4; k++) begin
      d  = 8'(8'h11 * (k + 1));
      oh = 4'b0001 << k;
      cy(4'b1111, 4'b1111, wd_rr, oh, 1'b1, 2'(k), prev_q);
      for (int h = 0; h < MAX_HOLD - 1; h++) begin
        cy(4'b1111, 4'b1111, wd_rr, oh, 1'b1, 2'(k), d);
      end
      cy(4'b1111, 4'b1111, wd_rr, 4'b0000, 1'b0, 2'(k), d);
      prev_q = d;
    end
    cy(4'b1111, 4'b1111, wd_rr, 4'b0001, 1'b1, 2'd0, 8'h44);
    cy(4'b1111, 4'b1111, wd_rr, 4'b0001, 1'b1, 2'd0, 8'h11);
    cy(4'b0000, 4'b1111, wd_rr, 4'b0000, 1'b0, 2'd0, 8'h11);

    // --- Voluntary release with write discarded, pending REQ[3] -----------
    cy(4'b1010, 4'b0000, 32'h0000_0000, 4'b0010, 1'b1, 2'd1, 8'h11);
    cy(4'b1010, 4'b0010, 32'h0000_5A00, 4'b0010, 1'b1, 2'd1, 8'h5A);
    cy(4'b1000, 4'b0010, 32'h0000_FF00, 4'b0000, 1'b0, 2'd1, 8'h5A);
    cy(4'b1000, 4'b0000, 32'h0000_0000, 4'b1000, 1'b1, 2'd3, 8'h5A);
    cy(4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 2'd3, 8'h5A);
    do_reset();

    // --- Non-owner write and sticky ERR ------------------------------------
    cyc(4'b0001, 4'b0000, 32'h0000_0000, 4'b0001, 1'b1, 2'd0, 8'h00, 1'b1, 1'b0);
    cyc(4'b0001, 4'b0001, 32'h0000_0012, 4'b0001, 1'b1, 2'd0, 8'h12, 1'b1, 1'b0);
    cyc(4'b0001, 4'b1000, 32'h7700_0099, 4'b0001, 1'b1, 2'd0, 8'h12, 1'b1, ERR_EN);
    cyc(4'b0001, 4'b0000, 32'h0000_0000, 4'b0001, 1'b1, 2'd0, 8'h12, 1'b1, ERR_EN);
    cyc(4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 2'd0, 8'h12, 1'b1, ERR_EN);
    do_reset();
    chk_reset_vals("after_err");

    // --- Wrap: owner 3 preempted by REQ[0] -------------------------------
    cy(4'b1000, 4'b0000, 32'h0000_0000, 4'b1000, 1'b1, 2'd3, 8'h00);
    cy(4'b1001, 4'b1000, 32'hC300_0000, 4'b1000, 1'b1, 2'd3, 8'hC3);
    cy(4'b1001, 4'b0000, 32'h0000_0000, 4'b1000, 1'b1, 2'd3, 8'hC3);
    cy(4'b1001, 4'b0000, 32'h0000_0000, 4'b1000, 1'b1, 2'd3, 8'hC3);
    cy(4'b1001, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 2'd3, 8'hC3);
    cy(4'b1001, 4'b0000, 32'h0000_0000, 4'b0001, 1'b1, 2'd0, 8'hC3);
    cy(4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 2'd0, 8'hC3);

    // Drain the scoreboard
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000");
    $fatal(1, "watchdog");
  end

endmodule
